// File: rtl/vga_timing_gen.sv
// 640x480@60 scan timing: pixel-enable divider, h/v counters, decoded syncs/bright, frame tick/count.
// Decoded outputs are combinational from the registered counters; free-running, no backpressure.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 783,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 514
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_en,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0] H_START_C = 10'(H_START);
  localparam logic [9:0] H_END_C   = 10'(H_END);
  localparam logic [9:0] V_START_C = 10'(V_START);
  localparam logic [9:0] V_END_C   = 10'(V_END);

  generate
    if (CLK_DIV == 1) begin : g_nodiv
      assign pix_en = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
      logic [DW-1:0] div;

      always_ff @(posedge clk) begin
        if (rst)                  div <= '0;
        else if (div == DIV_LAST) div <= '0;
        else                      div <= div + DW'(1);
      end

      assign pix_en = (div == DIV_LAST);
    end
  endgenerate

  // frame_tick is a one-clk pulse: cleared on every edge unless this edge wraps the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hCount     <= '0;
      vCount     <= '0;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (pix_en) begin
        if (hCount == H_LAST) begin
          hCount <= '0;
          if (vCount == V_LAST) begin
            vCount     <= '0;
            frame_tick <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end else begin
            vCount <= vCount + 10'd1;
          end
        end else begin
          hCount <= hCount + 10'd1;
        end
      end
    end
  end

  assign hSync  = ~(hCount < H_SYNC_C);
  assign vSync  = ~(vCount < V_SYNC_C);
  assign bright = (hCount >= H_START_C) && (hCount <= H_END_C) &&
                  (vCount >= V_START_C) && (vCount <= V_END_C);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: scaled-down timing on a main instance plus a tiny CLK_DIV=1 instance for frame_cnt wrap.
module tb_vga_timing_gen;

  localparam int M_CD = 4, M_HT = 20, M_HS = 3, M_HST = 6, M_HEN = 17;
  localparam int M_VT = 12, M_VS = 2, M_VST = 3, M_VEN = 10;
  localparam int S_CD = 1, S_HT = 4, S_HS = 1, S_HST = 1, S_HEN = 2;
  localparam int S_VT = 3, S_VS = 1, S_VST = 1, S_VEN = 1;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       br;
    logic       hs;
    logic       vs;
    logic       pe;
    logic       ft;
    logic [7:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_s = 1'b0;

  logic [9:0] hc, vc, hc_s, vc_s;
  logic br, hs, vs, pe, ft, br_s, hs_s, vs_s, pe_s, ft_s;
  logic [7:0] fc, fc_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(M_CD), .H_TOTAL(M_HT), .H_SYNC(M_HS), .H_START(M_HST), .H_END(M_HEN),
    .V_TOTAL(M_VT), .V_SYNC(M_VS), .V_START(M_VST), .V_END(M_VEN)
  ) u_main (
    .clk(clk), .rst(rst), .hCount(hc), .vCount(vc), .bright(br), .hSync(hs),
    .vSync(vs), .pix_en(pe), .frame_tick(ft), .frame_cnt(fc)
  );

  vga_timing_gen #(
    .CLK_DIV(S_CD), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_START(S_HST), .H_END(S_HEN),
    .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_START(S_VST), .V_END(S_VEN)
  ) u_small (
    .clk(clk), .rst(rst_s), .hCount(hc_s), .vCount(vc_s), .bright(br_s), .hSync(hs_s),
    .vSync(vs_s), .pix_en(pe_s), .frame_tick(ft_s), .frame_cnt(fc_s)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected outputs t clocks after the reset edge, from pixel-index arithmetic.
  function automatic obs_t model(input int t, input int cd, input int ht, input int hsn,
                                 input int hst, input int hen, input int vt, input int vsn,
                                 input int vst, input int ven);
    obs_t m;
    int p, line, h, v, fr;
    p    = t / cd;
    line = p / ht;
    h    = p % ht;
    v    = line % vt;
    fr   = line / vt;
    m.h  = 10'(h);
    m.v  = 10'(v);
    m.br = (h >= hst) && (h <= hen) && (v >= vst) && (v <= ven);
    m.hs = (h >= hsn);
    m.vs = (v >= vsn);
    m.pe = ((t % cd) == cd - 1);
    m.ft = (t > 0) && ((t % (cd * ht * vt)) == 0);
    m.fc = 8'(fr % 256);
    return m;
  endfunction

  int   t_m = 0, t_s = 0, cyc = 0;
  logic live_m = 1'b0, live_s = 1'b0;
  int   s_ticks = 0;
  int   s_fc255 = -1, s_fc256 = -1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin t_m <= 0; live_m <= 1'b1; end
    else t_m <= t_m + 1;
    if (rst_s) begin t_s <= 0; live_s <= 1'b1; end
    else t_s <= t_s + 1;
  end

  always @(negedge clk) begin
    if (live_m)
      check("main_model", longint'(obs_t'({hc, vc, br, hs, vs, pe, ft, fc})),
            longint'(model(t_m, M_CD, M_HT, M_HS, M_HST, M_HEN, M_VT, M_VS, M_VST, M_VEN)));
    if (live_s) begin
      check("small_model", longint'(obs_t'({hc_s, vc_s, br_s, hs_s, vs_s, pe_s, ft_s, fc_s})),
            longint'(model(t_s, S_CD, S_HT, S_HS, S_HST, S_HEN, S_VT, S_VS, S_VST, S_VEN)));
      if (ft_s) begin
        s_ticks <= s_ticks + 1;
        if (s_ticks == 254) s_fc255 <= int'(fc_s);
        if (s_ticks == 255) s_fc256 <= int'(fc_s);
      end
    end
  end

  task automatic wait_pos(input int h, input int v);
    int n = 0;
    while (!(int'(hc) == h && int'(vc) == v) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos_reached", longint'(n < 2000), 1);
  endtask

  task automatic wait_hwrap(output int at_cyc);
    int n = 0;
    logic [9:0] prev;
    prev = hc;
    @(negedge clk);
    while (!(prev == 10'(M_HT - 1) && hc == 10'd0) && n < 400) begin
      prev = hc;
      @(negedge clk);
      n++;
    end
    check("hwrap_seen", longint'(n < 400), 1);
    at_cyc = cyc;
  endtask

  task automatic wait_tick(output int at_cyc);
    int n = 0;
    while (ft !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", longint'(n < 2000), 1);
    at_cyc = cyc;
  endtask

  initial begin
    int hseq[9];
    int pseq[9];
    int c0, c1;
    hseq = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    pseq = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

    // Reset held for 3 clocks.
    rst = 1'b1; rst_s = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hcount", hc, 0);
    check("rst_vcount", vc, 0);
    check("rst_hsync", hs, 0);
    check("rst_vsync", vs, 0);
    check("rst_bright", br, 0);
    check("rst_pix_en", pe, 0);
    check("rst_tick", ft, 0);
    check("rst_frame_cnt", fc, 0);
    check("rst_small_pix_en", pe_s, 1);
    rst = 1'b0; rst_s = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("hcount_seq%0d", i), hc, hseq[i]);
      check($sformatf("pix_en_seq%0d", i), pe, pseq[i]);
    end

    // One full line.
    wait_hwrap(c0);
    check("vcount_after_line0", vc, 1);
    wait_hwrap(c1);
    check("vcount_after_line1", vc, 2);
    check("line_period", c1 - c0, M_HT * M_CD);

    wait_pos(2, 2);
    check("hsync_last_low", hs, 0);
    wait_pos(3, 2);
    check("hsync_first_high", hs, 1);

    // Visible window corners.
    wait_pos(5, 3);
    check("bright_left_out", br, 0);
    wait_pos(6, 3);
    check("bright_top_left", br, 1);
    wait_pos(18, 3);
    check("bright_right_out", br, 0);
    wait_pos(17, 10);
    check("bright_bot_right", br, 1);
    wait_pos(6, 11);
    check("bright_below", br, 0);

    // Frame boundary.
    wait_tick(c0);
    check("tick_h", hc, 0);
    check("tick_v", vc, 0);
    check("tick_frame_cnt", fc, 1);
    @(negedge clk);
    check("tick_width", ft, 0);
    wait_pos(0, 1);
    check("vsync_line1", vs, 0);
    wait_pos(0, 2);
    check("vsync_line2", vs, 1);
    wait_pos(6, 2);
    check("bright_above", br, 0);
    wait_tick(c1);
    check("tick_period", c1 - c0, M_CD * M_HT * M_VT);
    check("tick_frame_cnt2", fc, 2);

    // Reset mid-frame with div=2.
    wait_pos(10, 5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hcount", hc, 0);
    check("midrst_vcount", vc, 0);
    check("midrst_frame_cnt", fc, 0);
    check("midrst_pix_en_t0", pe, 0);
    @(negedge clk);
    check("midrst_pix_en_t1", pe, 0);
    @(negedge clk);
    check("midrst_pix_en_t2", pe, 0);
    @(negedge clk);
    check("midrst_pix_en_t3", pe, 1);
    @(negedge clk);
    check("midrst_hcount_t4", hc, 1);

    // frame_cnt wrap on the small instance.
    begin
      int n = 0;
      while (s_ticks < 256 && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("small_ticks_reached", longint'(s_ticks >= 256), 1);
    end
    check("small_fc_at_255", s_fc255, 255);
    check("small_fc_wrap", s_fc256, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
